// File: rtl/adder_1bit_pkg.sv
// Datapath-wide constants shared by the arithmetic leaf cells.
package adder_1bit_pkg;
  localparam int ADDER_LATENCY = 1;
endpackage

// File: rtl/adder_1bit_full_adder_core.sv
// Combinational full-adder core; also the bit cell of the 16-bit ripple adder.
module full_adder_core
  import adder_1bit_pkg::*;
(
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);
  logic p;

  assign p    = a ^ b;
  assign sum  = p ^ cin;
  assign cout = (a & b) | (cin & p);
endmodule

// File: rtl/adder_1bit.sv
// Clocked 1-bit full adder with valid-qualified outputs and an optional
// bit-serial mode that recirculates the registered carry.
module adder_1bit
  import adder_1bit_pkg::*;
#(
  parameter bit OUT_REG = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  logic a,
  input  logic b,
  input  logic c_in,
  input  logic serial_en,
  input  logic serial_start,
  output logic s,
  output logic c_out,
  output logic out_valid,
  output logic carry_q
);
  logic cin_eff, sum_n, cout_n, carry_d;

  // serial_start forces the external carry so each serial word begins clean
  always_comb cin_eff = (!serial_en || serial_start) ? c_in : carry_q;

  full_adder_core u_core (
    .a    (a),
    .b    (b),
    .cin  (cin_eff),
    .sum  (sum_n),
    .cout (cout_n)
  );

  always_comb begin
    carry_d = carry_q;
    if (in_valid) carry_d = cout_n;
  end

  always_ff @(posedge clk) begin
    if (rst) carry_q <= 1'b0;
    else     carry_q <= carry_d;
  end

  generate
    if (OUT_REG) begin : g_reg
      logic s_q, s_d, c_out_q, c_out_d, vld_q, vld_d;

      always_comb begin
        s_d     = s_q;
        c_out_d = c_out_q;
        vld_d   = in_valid;
        if (in_valid) begin
          s_d     = sum_n;
          c_out_d = cout_n;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          s_q     <= 1'b0;
          c_out_q <= 1'b0;
          vld_q   <= 1'b0;
        end else begin
          s_q     <= s_d;
          c_out_q <= c_out_d;
          vld_q   <= vld_d;
        end
      end

      assign s         = s_q;
      assign c_out     = c_out_q;
      assign out_valid = vld_q;
    end else begin : g_comb
      assign s         = sum_n;
      assign c_out     = cout_n;
      assign out_valid = in_valid;
    end
  endgenerate
endmodule

// File: tb/tb_adder_1bit.sv
// Scoreboard bench for adder_1bit: registered and combinational variants side by side.
module tb_adder_1bit;
  logic clk = 1'b0;
  logic rst, in_valid, a, b, c_in, serial_en, serial_start;
  logic s1, c1, v1, cq1;
  logic s0, c0, v0, cq0;

  int n_cmp = 0;
  int n_err = 0;
  logic [1:0] sb[$];
  logic       m_carry = 1'b0;

  always #10 clk = ~clk;

  adder_1bit #(.OUT_REG(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in),
    .serial_en(serial_en), .serial_start(serial_start),
    .s(s1), .c_out(c1), .out_valid(v1), .carry_q(cq1)
  );

  adder_1bit #(.OUT_REG(1'b0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .a(a), .b(b), .c_in(c_in),
    .serial_en(serial_en), .serial_start(serial_start),
    .s(s0), .c_out(c0), .out_valid(v0), .carry_q(cq0)
  );

  task automatic chk(input string tag, input logic [1:0] got, input logic [1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b, want %b", tag, got, exp);
    end
  endtask

  // drive one cycle of stimulus after the edge; push the expected {s,c_out}
  task automatic drv(input logic v, input logic ia, input logic ib, input logic ic,
                     input logic se, input logic ss);
    logic       cin;
    logic [1:0] tot;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = v; a = ia; b = ib; c_in = ic;
    serial_en = se; serial_start = ss;
    if (v) begin
      cin = (!se || ss) ? ic : m_carry;
      tot = 2'(ia) + 2'(ib) + 2'(cin);
      sb.push_back({tot[0], tot[1]});
      m_carry = tot[1];
    end
  endtask

  task automatic idle();
    drv(1'b0, 1'bx, 1'bx, 1'bx, 1'bx, 1'bx);
  endtask

  // 1011 + 0110 LSB first, optional stall before the third bit
  task automatic serial_word(input bit gap);
    logic [3:0] wa, wb;
    wa = 4'b1011;
    wb = 4'b0110;
    for (int i = 0; i < 4; i++) begin
      if (gap && i == 2) idle();
      drv(1'b1, wa[i], wb[i], 1'b0, 1'b1, i == 0);
    end
    idle();
    @(negedge clk);
    chk("ser_carry", 2'(cq1), 2'b01);
    chk("ser_msb", {s1, c1}, 2'b01);
  endtask

  always @(negedge clk) begin
    if (v1 === 1'b1) begin
      if (sb.size() == 0) chk("sb_unexpected", 2'(v1), 2'b00);
      else chk("sc", {s1, c1}, sb.pop_front());
    end
  end

  initial begin
    rst = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1; c_in = 1'b1;
    serial_en = 1'b0; serial_start = 1'b0;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_sc", {s1, c1}, 2'b00);
      chk("rst_vld", 2'(v1), 2'b00);
      chk("rst_carry", 2'(cq1), 2'b00);
    end
    m_carry = 1'b0;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = 3'(i);
      drv(1'b1, v[2], v[1], v[0], 1'b0, 1'b0);
    end

    idle();
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("hold_vld", 2'(v1), 2'b00);
      chk("hold_sc", {s1, c1}, 2'b11);
      chk("hold_carry", 2'(cq1), 2'b01);
    end

    serial_word(1'b0);
    serial_word(1'b1);

    // reset lands after bit 2 of a word whose carry is then 1
    drv(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b1; a = 1'b1; b = 1'b1; c_in = 1'b1;
    m_carry = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("midrst_carry", 2'(cq1), 2'b00);
    chk("midrst_vld", 2'(v1), 2'b00);
    serial_word(1'b0);

    // combinational variant answers in the same cycle
    drv(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("comb_sc", {s0, c0}, 2'b01);
    chk("comb_vld", 2'(v0), 2'b01);
    idle();
    #1;
    chk("comb_vld_low", 2'(v0), 2'b00);
    chk("comb_carry", 2'(cq0), 2'b01);

    repeat (3) @(negedge clk);
    chk("sb_drained", 2'(sb.size() != 0), 2'b00);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/adder_1bit.md
Name: adder_1bit

Overview:
Clocked 1-bit full-adder cell, the leaf arithmetic element of the 16-bit processor datapath.
- Computes S = A xor B xor Cin and Cout = majority(A, B, Cin), with registered, valid-qualified outputs.
- Optional bit-serial mode feeds the registered carry back as the next carry-in, so one instance can add multi-bit operands LSB-first.

Parameters:
- OUT_REG, 1: 1 registers s/c_out/out_valid (latency 1 cycle); 0 drives them combinationally from the current inputs (latency 0). carry_q is always registered.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand bits present this cycle.
- a  input  1  operand bit A.
- b  input  1  operand bit B.
- c_in  input  1  external carry-in.
- serial_en  input  1  1 = use internal carry_q as carry-in (bit-serial mode).
- serial_start  input  1  first bit of a serial word; carry-in taken from c_in this cycle.
- s  output  1  sum bit.
- c_out  output  1  carry-out bit.
- out_valid  output  1  s/c_out are valid.
- carry_q  output  1  registered carry state.

Behaviour:
- Carry select: cin_eff = c_in when (serial_en = 0) or (serial_start = 1); otherwise cin_eff = carry_q.
- Arithmetic: sum_n = a ^ b ^ cin_eff; cout_n = (a & b) | (cin_eff & (a ^ b)). Truth table: 000->s0 c0, 001->10, 010->10, 011->01, 100->10, 101->01, 110->01, 111->11 (inputs a b cin; outputs s c).
- Reset (rst = 1 at a rising edge): s = 0, c_out = 0, out_valid = 0, carry_q = 0. Reset overrides in_valid in the same cycle, including mid serial word; the next word must restart with serial_start.
- OUT_REG = 1, in_valid = 1 at an edge: s <= sum_n, c_out <= cout_n, out_valid <= 1, carry_q <= cout_n.
- OUT_REG = 1, in_valid = 0 at an edge: out_valid <= 0. s, c_out and carry_q hold their values. A serial word may stall across idle cycles without losing carry.
- OUT_REG = 0: s = sum_n, c_out = cout_n, out_valid = in_valid, all combinational. carry_q updates exactly as in OUT_REG = 1.
- serial_start without serial_en: no effect beyond the normal c_in path.
- X/Z on inputs while in_valid = 0 must not corrupt any state.
- No back-pressure: every valid input produces exactly one valid output.

Decomposition:
- No shared package types are needed. Add one shared constant, ADDER_LATENCY = 1, to the datapath package.
- Sub-module full_adder_core: purely combinational (a, b, cin) -> (sum, cout). The same core is reused by the 16-bit ripple adder; adder_1bit wraps it with carry select and registers.

Test Plan:
- Reset: hold rst = 1 for 2 cycles with in_valid = 1, a = b = c_in = 1 -> s = 0, c_out = 0, out_valid = 0, carry_q = 0.
- Exhaustive truth table: serial_en = 0, in_valid = 1; apply a, b, c_in counting 000 through 111, one vector per 20 ns step (each new vector toggles the LSB, the middle bit every 2 steps and the MSB every 4 steps). One cycle later, required (s, c_out) = 00, 10, 10, 01, 10, 01, 01, 11.
- Hold/idle: after vector 111, drop in_valid for 3 cycles -> out_valid = 0; s = 1, c_out = 1 and carry_q = 1 unchanged.
- Bit-serial add 0b1011 + 0b0110 (LSB first, 4 cycles, serial_en = 1, serial_start on the first bit, c_in = 0) -> s sequence 1, 0, 0, 0; final carry_q = 1 (result 10001).
- Serial stall and reset mid-word:
  - Insert an in_valid = 0 gap between bits 2 and 3 of the serial add -> same result as without the gap.
  - Assert rst after bit 2 -> carry_q = 0 and out_valid = 0 on the next cycle.
- OUT_REG = 0 variant: apply a = 1, b = 1, c_in = 0 -> s = 0 and c_out = 1 in the same cycle; out_valid follows in_valid combinationally.
